// File: rtl/mem_responder.sv
// Word-organised RAM responder for the req/gnt/rvalid memory protocol, with programmable latencies.
// Define MEM_RESP_ERR_EN to add data_err_o and out-of-range access checking.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned GNT_LATENCY    = 1,
  parameter int unsigned RVALID_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                    data_err_o
`endif
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned MaxLat   = (GNT_LATENCY > RVALID_LATENCY) ? GNT_LATENCY : RVALID_LATENCY;
  localparam int unsigned CntW     = $clog2(MaxLat + 1);

  localparam logic [CntW-1:0]       GntLoad = CntW'(GNT_LATENCY - 1);
  localparam logic [CntW-1:0]       RvLoad  = CntW'(RVALID_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] ErrData = DATA_WIDTH'(32'hDEADBEEF);

  typedef enum logic [1:0] {StIdle, StGntWait, StRespWait, StResp} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  gnt_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  resp_err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [IdxW-1:0] idx;
  logic            oor;
  logic            commit;
  logic            write_en;

  // Upper address bits and addr[1:0] are dropped, so the RAM aliases modulo its size.
  assign idx = data_addr_i[2 +: IdxW];

`ifdef MEM_RESP_ERR_EN
  localparam logic [ADDR_WIDTH:0] ByteLimit = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);
  assign oor        = ({1'b0, data_addr_i} >= ByteLimit);
  assign data_err_o = err_q;
`else
  assign oor = 1'b0;
  logic unused_addr;
  logic unused_err;
  assign unused_addr = ^data_addr_i;
  assign unused_err  = err_q;
`endif

  // The grant edge is where the access takes effect; reset on that edge drops it.
  assign commit   = (state_q == StGntWait) && data_req_i && (cnt_q == '0);
  assign write_en = commit && data_we_i && !oor && !rst_i;

  always_ff @(posedge clk_i) begin : ram_write
    if (write_en) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (data_be_i[i]) begin
          mem_q[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin : fsm
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      resp_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      unique case (state_q)
        // RESP accepts a new request too, so back-to-back transactions lose no cycle.
        StIdle, StResp: begin
          if (data_req_i) begin
            state_q <= StGntWait;
            cnt_q   <= GntLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        StGntWait: begin
          if (!data_req_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            gnt_q      <= 1'b1;
            state_q    <= StRespWait;
            cnt_q      <= RvLoad;
            resp_err_q <= oor;
            if (data_we_i) begin
              resp_q <= '0;
            end else if (oor) begin
              resp_q <= ErrData;
            end else begin
              resp_q <= mem_q[idx];
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StRespWait: begin
          if (cnt_q == '0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= resp_q;
            err_q    <= resp_err_q;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_gnt_o    = gnt_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (latencies 1/1 and 3/2) driven with directed
// and random transactions, checked against a byte-array RAM model and cycle-exact timing rules.
module tb_mem_responder;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges so far; read on the falling edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input int k, input logic [DW-1:0] act,
                                input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst%0d cycle %0d: got %h, want %h", name, k, cyc, act, req);
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int unsigned GL = (k == 0) ? 1 : 3;
    localparam int unsigned RL = (k == 0) ? 1 : 2;

    logic          rst   = 1'b1;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [3:0]    be    = '0;
    logic [DW-1:0] wdata = '0;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    bit            done = 1'b0;
`ifdef MEM_RESP_ERR_EN
    logic          err;
`endif

    // First edge at which the responder can accept a new request.
    int unsigned   free_edge = 0;
    int unsigned   gnt_exp[$];
    exp_t          rv_exp[$];
    logic [DW-1:0] ref_mem [DEPTH];

    mem_responder #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .DEPTH_WORDS   (DEPTH),
      .GNT_LATENCY   (GL),
      .RVALID_LATENCY(RL)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_req_i   (req),
      .data_gnt_o   (gnt),
      .data_rvalid_o(rvalid),
      .data_addr_i  (addr),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_wdata_i (wdata),
      .data_rdata_o (rdata)
`ifdef MEM_RESP_ERR_EN
      ,
      .data_err_o   (err)
`endif
    );

    always @(negedge clk) begin : monitor
      exp_t        e;
      int unsigned g;
      if (cyc >= 1) begin
        check("gnt_rvalid_overlap", k, DW'(gnt & rvalid), '0);
        if (gnt) begin
          check("gnt_expected", k, DW'(gnt_exp.size() != 0), 1);
          if (gnt_exp.size() != 0) begin
            g = gnt_exp.pop_front();
            check("gnt_cycle", k, cyc, g);
          end
        end
        if (rvalid) begin
          check("rvalid_expected", k, DW'(rv_exp.size() != 0), 1);
          if (rv_exp.size() != 0) begin
            e = rv_exp.pop_front();
            check("rvalid_cycle", k, cyc, e.cyc);
            check("rdata", k, rdata, e.rdata);
`ifdef MEM_RESP_ERR_EN
            check("err", k, DW'(err), DW'(e.err));
`endif
          end
        end else begin
          check("rdata_idle", k, rdata, '0);
`ifdef MEM_RESP_ERR_EN
          check("err_idle", k, DW'(err), '0);
`endif
        end
      end
    end

    // Called on a falling edge; returns on the falling edge where gnt is seen (or after reset).
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                         input logic [DW-1:0] d, input bit abort);
      int unsigned acc;
      int unsigned idx;
      int          n;
      bit          oor;
      exp_t        e;
      req   = 1'b1;
      we    = w;
      addr  = a;
      be    = b;
      wdata = d;
      acc   = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
      gnt_exp.push_back(acc + GL);
      idx = (32'(a) >> 2) % DEPTH;
`ifdef MEM_RESP_ERR_EN
      oor = (32'(a) >= DEPTH * 4);
`else
      oor = 1'b0;
`endif
      e.cyc = acc + GL + RL;
      e.err = oor;
      if (oor) begin
        e.rdata = w ? 32'h0 : 32'hDEADBEEF;
      end else if (w) begin
        e.rdata = '0;
        for (int i = 0; i < 4; i++) begin
          if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        e.rdata = ref_mem[idx];
      end
      if (!abort) rv_exp.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!gnt && n < 40);
      check("gnt_seen", k, DW'(gnt), 1);
      req = 1'b0;
      if (abort) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_gnt", k, DW'(gnt), '0);
        check("abort_rvalid", k, DW'(rvalid), '0);
        check("abort_rdata", k, rdata, '0);
        rst       = 1'b0;
        free_edge = cyc + 1;
      end else begin
        free_edge = acc + GL + RL + 1;
      end
    endtask

    // Request withdrawn after one cycle: no grant may follow.
    task automatic req_drop(input logic [AW-1:0] a);
      int gnts;
      while (cyc + 1 < free_edge) @(negedge clk);
      req  = 1'b1;
      we   = 1'b0;
      addr = a;
      be   = 4'hF;
      @(negedge clk);
      req  = 1'b0;
      gnts = 0;
      repeat (GL + 4) begin
        @(negedge clk);
        gnts += int'(gnt);
      end
      check("drop_no_gnt", k, gnts, '0);
      free_edge = cyc + 1;
    endtask

    initial begin : driver
      logic [AW-1:0] a;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt", k, DW'(gnt), '0);
      check("rst_rvalid", k, DW'(rvalid), '0);
      check("rst_rdata", k, rdata, '0);
      rst       = 1'b0;
      free_edge = cyc + 1;

      issue(1'b1, 16'h0010, 4'hF, 32'hA5A5_1234, 1'b0);
      issue(1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
      issue(1'b1, 16'h0010, 4'b0101, 32'hFFFF_FFFF, 1'b0);
      issue(1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
      issue(1'b1, 16'h0004, 4'hF, 32'h1111_2222, 1'b0);
      issue(1'b0, 16'h1004, 4'hF, 32'h0, 1'b0);
      issue(1'b1, 16'h0020, 4'hF, 32'h0000_00FF, 1'b0);
      issue(1'b1, 16'h0020, 4'h0, 32'hFFFF_FFFF, 1'b0);
      issue(1'b0, 16'h0020, 4'hF, 32'h0, 1'b0);
      req_drop(16'h0010);
      issue(1'b0, 16'h0010, 4'hF, 32'h0, 1'b1);
      issue(1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);

      for (int t = 0; t < 40; t++) begin
        a = AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a[15:12] = 4'($urandom_range(0, 15));
        issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      while (cyc < free_edge + 2) @(negedge clk);
      check("gnt_queue_drained", k, gnt_exp.size(), '0);
      check("rvalid_queue_drained", k, rv_exp.size(), '0);
      done = 1'b1;
    end
  end

  initial begin : finisher
    fork
      wait (g_inst[0].done && g_inst[1].done);
      #200000;
    join_any
    if (!(g_inst[0].done && g_inst[1].done)) begin
      failures++;
      $display("FAIL watchdog: drivers done=%0d%0d, want 11", g_inst[0].done, g_inst[1].done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
